// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed WIDTH-bit multiply / divide engine.
// One start pulse latches operands; WIDTH iterations later a one-cycle
// data_resultRDY pulse presents the product low word or the quotient.
// Optional feature macro: MULTDIV_DIV_EN compiles in the restoring divider.
// Without it a divide start completes on the next edge with result 0 and
// data_exception set.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    // one-hot progress: bit 0 after a start, bit WIDTH marks the RDY cycle
    logic [WIDTH:0]     r_iter;
    logic               w_last;
    logic               w_start;

    // multiplier datapath
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_ovf;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = r_iter[WIDTH-1];

    assign busy           = (r_state == S_MUL) || (r_state == S_DIV);
    assign data_resultRDY = r_iter[WIDTH];

    // shift-add: the final step carries the multiplier sign bit, whose
    // two's-complement weight is negative, so it subtracts instead of adds
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_prod_nxt = w_last ? (r_prod - w_addend) : (r_prod + w_addend);
        w_prod_hi  = w_prod_nxt[2*WIDTH-1:WIDTH-1];
        w_mul_ovf  = ~((&w_prod_hi) | ~(|w_prod_hi));
    end

`ifdef MULTDIV_DIV_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // divider datapath: restoring division on operand magnitudes
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_neg;
    logic             r_dzero;
    logic             r_dovf;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_div_res;
    logic             w_div_exc;

    // magnitudes at start, one quotient bit per iteration, sign fix-up at the end
    always_comb begin
        w_abs_a   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        w_abs_b   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_rem_sub = w_rem_sh - {1'b0, r_dvsr};
        w_ge      = r_rem[WIDTH] | (w_rem_sh >= {1'b0, r_dvsr});
        w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh;
        w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
        w_div_exc = r_dzero | r_dovf;
        if (r_dzero)
            w_div_res = '0;
        else if (r_dovf)
            w_div_res = MIN_NEG;
        else
            w_div_res = r_neg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    end

    // divider operand latch and iteration
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_neg   <= 1'b0;
            r_dzero <= 1'b0;
            r_dovf  <= 1'b0;
        end else if (ctrl_DIV && !ctrl_MULT) begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dvsr  <= w_abs_b;
            r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dzero <= (data_operandB == '0);
            r_dovf  <= (data_operandA == MIN_NEG) && (&data_operandB);
        end else if (r_state == S_DIV) begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
        end
    end
`endif

    // next state: a start pulse wins from any state, MULT over DIV
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_MUL:   if (w_last) w_state_nxt = S_DONE;
`ifdef MULTDIV_DIV_EN
            S_DIV:   if (w_last) w_state_nxt = S_DONE;
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (ctrl_MULT)
            w_state_nxt = S_MUL;
        else if (ctrl_DIV)
`ifdef MULTDIV_DIV_EN
            w_state_nxt = S_DIV;
`else
            w_state_nxt = S_DONE;
`endif
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // tracker, multiplier iteration and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_iter         <= '0;
            r_prod         <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (w_start) begin
            r_iter <= {{WIDTH{1'b0}}, 1'b1};
            if (ctrl_MULT) begin
                r_prod   <= '0;
                r_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                r_mplier <= data_operandB;
            end
`ifndef MULTDIV_DIV_EN
            else begin
                // no divider: complete immediately with an exception
                r_iter         <= {1'b1, {WIDTH{1'b0}}};
                data_result    <= '0;
                data_exception <= 1'b1;
            end
`endif
        end else begin
            case (r_state)
                S_MUL: begin
                    r_iter   <= r_iter << 1;
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        data_result    <= w_prod_nxt[WIDTH-1:0];
                        data_exception <= w_mul_ovf;
                    end
                end
`ifdef MULTDIV_DIV_EN
                S_DIV: begin
                    r_iter <= r_iter << 1;
                    if (w_last) begin
                        data_result    <= w_div_res;
                        data_exception <= w_div_exc;
                    end
                end
`endif
                default: r_iter <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: random and directed multiply/divide operations
// compared against plain-arithmetic expectations, with latency, busy and
// RDY-pulse accounting per operation.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: exact 64-bit product and truncating integer division
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     qa;
        int     qb;
        int     q;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (!DIV_EN) begin
            r = 32'h0;
            e = 1'b1;
        end else begin
            qa = $signed(a);
            qb = $signed(b);
            if (qb == 0) begin
                r = 32'h0;
                e = 1'b1;
            end else if (a == 32'h8000_0000 && qb == -1) begin
                r = 32'h8000_0000;
                e = 1'b1;
            end else begin
                q = qa / qb;
                r = q;
                e = 1'b0;
            end
        end
    endfunction

    // drive a start pulse at the current negedge; return at the negedge after the start edge
    task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // one full operation; with chain set, return in the RDY cycle so the next start overlaps it
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit chain);
        logic [31:0] er, r;
        logic        ee, e;
        int          lat, rdy_at, rdy_cnt, busy_cnt;
        model(m, a, b, er, ee);
        lat      = (m || DIV_EN) ? 32 : 0;
        rdy_at   = -1;
        rdy_cnt  = 0;
        busy_cnt = 0;
        r        = 'x;
        e        = 1'bx;
        launch(m, d, a, b);
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) @(negedge clock);
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at = j;
                    r      = data_result;
                    e      = data_exception;
                end
            end
            if (chain && rdy_at >= 0) break;
        end
        chk("rdy_latency", rdy_at, lat);
        chk("busy_cycles", busy_cnt, lat);
        chk("rdy_pulses", rdy_cnt, 1);
        chk("result", r, er);
        chk("exception", e, ee);
        if (!chain) begin
            chk("result_hold", data_result, er);
            chk("exc_hold", data_exception, ee);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bit          m, ch;
        int          rdy_cnt;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_result", data_result, 32'h0);
        chk("rst_exc", data_exception, 1'b0);
        chk("rst_rdy", data_resultRDY, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // directed cases
        do_op(1'b1, 1'b0, 32'd7, -32'sd6, 1'b0);
        do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        do_op(1'b0, 1'b1, -32'sd17, 32'd5, 1'b0);
        do_op(1'b0, 1'b1, 32'd100, 32'd0, 1'b0);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b0, 1'b1, 32'd9, 32'd3, 1'b0);

        // abandoned multiply: restart with a divide ten cycles in
        launch(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        do_op(1'b0, 1'b1, 32'd20, 32'd4, 1'b0);

        // both start lines together: multiply wins
        do_op(1'b1, 1'b1, 32'd2, 32'd3, 1'b0);

        // back-to-back starts landing in the RDY cycle
        do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        do_op(1'b1, 1'b0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0);

        // randomized operations with mixed operand sizes
        for (int i = 0; i < 24; i++) begin
            m  = $urandom_range(0, 1);
            ch = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 200) - 100;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = $urandom_range(0, 20) - 10;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_op(m, !m, a, b, ch);
        end

        // reset in the middle of an operation
        launch(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0100);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_result", data_result, 32'h0);
        chk("midrst_exc", data_exception, 1'b0);
        chk("midrst_rdy", data_resultRDY, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        reset   = 1'b0;
        rdy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_cnt++;
        end
        chk("midrst_quiet", rdy_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Iterative signed 32-bit multiply/divide engine, driven by the execute stage. A one-cycle `ctrl_MULT` or `ctrl_DIV` pulse latches the operands and starts the operation. The block then sequences 32 iterations internally and returns the result with a one-cycle `data_resultRDY` pulse. While `busy` is high, the pipeline holds the issuing instruction in execute.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `ctrl_MULT` in 1: start pulse for a signed multiply.
- `ctrl_DIV` in 1: start pulse for a signed divide.
- `data_operandA` in WIDTH: multiplicand or dividend; sampled only on a start edge.
- `data_operandB` in WIDTH: multiplier or divisor; sampled only on a start edge.
- `data_result` out WIDTH: product low word or quotient; registered, held until the next completion.
- `data_exception` out 1: overflow or divide-by-zero; registered, valid with `data_resultRDY`, held with the result.
- `data_resultRDY` out 1: one-cycle completion pulse.
- `busy` out 1: operation in flight.

## Operation
- States: IDLE, MUL, DIV, DONE. A one-hot iteration tracker (WIDTH+1 bits) marks progress; entering MUL/DIV loads bit 0.
- Start: on an edge where `ctrl_MULT` or `ctrl_DIV` is high, operands are latched, the tracker is cleared to bit 0, and the state moves to MUL or DIV. This happens from any state.
- Both start lines high on the same edge: MULT wins, DIV is ignored.
- Restart while in MUL/DIV/DONE: the current operation is abandoned and gives no RDY pulse for it. The new operation starts fresh.
- MUL: radix-2 shift-add on a 2·WIDTH-bit signed product, one multiplier bit per edge.
  - Result: low WIDTH bits.
  - `data_exception`=1 when the upper WIDTH+1 bits of the full product are not all equal (signed overflow).
- DIV: restoring division on magnitudes, one quotient bit per edge. Quotient sign = sign(A) XOR sign(B); truncates toward zero; remainder discarded.
  - B==0: result 0, `data_exception`=1; the full latency still applies.
  - A=0x80000000, B=-1: result 0x80000000, `data_exception`=1.
- After the WIDTH-th iteration, the state moves to DONE: `data_result`/`data_exception` are loaded and `data_resultRDY`=1. The next edge moves to IDLE unless a start is present.
- `busy` = state is MUL or DIV.
- Operand inputs are don't-care outside start edges.
- Reset values: state IDLE, tracker 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0. Reset overrides a simultaneous start.

## Timing
- Start sampled at edge N.
- `busy` is high from after edge N through edge N+32.
- `data_resultRDY` is high for exactly the one cycle after edge N+32 (latency 32 cycles start-to-RDY).
- A start at edge N+32+1, during the RDY cycle, is accepted. Back-to-back throughput is one operation per 33 cycles.
- Result registers change only at the DONE-entry edge or on reset.
- Reset mid-operation returns to IDLE at that edge; no RDY pulse follows.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `MULTDIV_DIV_EN` defined: divider datapath and DIV state compiled in, behaviour as above.
- `MULTDIV_DIV_EN` undefined: no divider logic.
  - `ctrl_DIV` (with `ctrl_MULT` low) moves directly to DONE on the next edge: `data_result`=0, `data_exception`=1, RDY 1 cycle after the start edge, `busy` never asserts.
  - Multiply is unchanged.

## Test plan
- Reset, then MULT A=7, B=-6 -> `busy` high 32 cycles; RDY pulse exactly 32 cycles after start; result 0xFFFFFFD6, exception 0.
- MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1 (overflow).
- DIV A=-17, B=5 -> result 0xFFFFFFFD (-3), exception 0; DIV A=100, B=0 -> result 0, exception 1, same 32-cycle latency.
- MULT A=3, B=4 started, then DIV A=20, B=4 at cycle 10 -> no RDY at cycle 32; single RDY 32 cycles after the DIV edge with result 5.
- MULT and DIV high together with A=2, B=3 -> result 6; reset asserted at cycle 15 of an operation -> all outputs 0, no RDY afterward.
- Build without `MULTDIV_DIV_EN`: DIV A=9, B=3 -> RDY one cycle later, result 0, exception 1, `busy` stays 0.
